r_enc_ctrl: RTL and testbench



---
 rtl/r_enc_ctrl.sv | 145 ++++++++++++++
 tb/tb_r_enc_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/r_enc_ctrl.sv
// r_enc_ctrl: rotary-encoder setting controller.
// Takes the decoded encoder stream (one-cycle event pulse and a direction bit)
// and drives an adjustable setting. The working value saturates at the
// MIN_VAL/MAX_VAL limits, and steps by FAST_STEP when the encoder is turned
// quickly in one direction. The controller runs an edit session and hands the
// final value downstream through a valid/ready commit handshake.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   rlr[1:0]      bit1 = event pulse, bit0 = direction (1 = decrement)
//   btn_press     one-cycle commit request
//   value         registered working value
//   editing       high while an edit session is open
//   commit_valid  commit_data valid, held until commit_ready
//   commit_ready  downstream accept
//   commit_data   last committed value
module r_enc_ctrl #(
  parameter int WIDTH     = 8,
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 255,
  parameter int INIT_VAL  = 0,
  parameter int FAST_CYC  = 500000,
  parameter int FAST_STEP = 8,
  parameter int IDLE_CYC  = 50000000,
  parameter int TW        = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       rlr,
  input  logic             btn_press,
  output logic [WIDTH-1:0] value,
  output logic             editing,
  output logic             commit_valid,
  input  logic             commit_ready,
  output logic [WIDTH-1:0] commit_data
);

  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT} state_e;

  localparam logic [WIDTH-1:0] INIT_V    = WIDTH'(INIT_VAL);
  localparam logic [WIDTH:0]   MIN_E     = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MAX_E     = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   FAST_S    = (WIDTH+1)'(FAST_STEP);
  localparam logic [WIDTH:0]   ONE_S     = (WIDTH+1)'(1);
  localparam logic [TW-1:0]    FAST_T    = TW'(FAST_CYC);
  localparam logic [TW-1:0]    IDLE_LAST = TW'(IDLE_CYC - 1);

  // Saturating step in WIDTH+1 bits so an increment past MAX_VAL cannot wrap.
  // The value is always >= MIN_VAL, so (v - MIN) cannot underflow.
  function automatic logic [WIDTH-1:0] step_sat(input logic [WIDTH-1:0] v,
                                                input logic             dec,
                                                input logic [WIDTH:0]   step);
    logic [WIDTH:0] ext;
    logic [WIDTH:0] res;
    ext = {1'b0, v};
    if (dec) begin
      if ((ext - MIN_E) < step) res = MIN_E;
      else                      res = ext - step;
    end else begin
      res = ext + step;
      if (res > MAX_E) res = MAX_E;
    end
    return res[WIDTH-1:0];
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] cdata_q, cdata_d;
  logic [TW-1:0]    gap_q, gap_d;
  logic [TW-1:0]    idle_q, idle_d;
  logic             last_dir_q, last_dir_d;

  logic             ev, dir, fast;
  logic [WIDTH-1:0] stepped;

  assign ev  = rlr[1];
  assign dir = rlr[0];
  // Acceleration only inside a session, on a quick same-direction event.
  assign fast    = (state_q == S_EDIT) && (gap_q < FAST_T) && (dir == last_dir_q);
  assign stepped = step_sat(value_q, dir, fast ? FAST_S : ONE_S);

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    cdata_d    = cdata_q;
    gap_d      = (gap_q < FAST_T) ? gap_q + 1'b1 : gap_q;
    idle_d     = '0;
    last_dir_d = last_dir_q;
    case (state_q)
      S_IDLE: begin
        if (ev) begin
          value_d    = stepped;
          gap_d      = '0;
          last_dir_d = dir;
          state_d    = S_EDIT;
        end
      end
      S_EDIT: begin
        if (ev) begin
          value_d    = stepped;
          gap_d      = '0;
          last_dir_d = dir;
        end else begin
          idle_d = idle_q + 1'b1;
        end
        // Timeout only fires on a quiet cycle so it always lands exactly
        // IDLE_CYC cycles after the last value change. A same-cycle event
        // and button commit the stepped value.
        if (btn_press || (!ev && (idle_q == IDLE_LAST))) begin
          state_d = S_COMMIT;
          cdata_d = value_d;
        end
      end
      S_COMMIT: begin
        if (commit_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      value_q    <= INIT_V;
      cdata_q    <= INIT_V;
      gap_q      <= FAST_T;
      idle_q     <= '0;
      last_dir_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      cdata_q    <= cdata_d;
      gap_q      <= gap_d;
      idle_q     <= idle_d;
      last_dir_q <= last_dir_d;
    end
  end

  assign value        = value_q;
  assign commit_data  = cdata_q;
  assign editing      = (state_q == S_EDIT);
  assign commit_valid = (state_q == S_COMMIT);

endmodule

// File: tb/tb_r_enc_ctrl.sv
module tb_r_enc_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] rlr;
  logic       btn_press;
  logic [7:0] value;
  logic       editing;
  logic       commit_valid;
  logic       commit_ready;
  logic [7:0] commit_data;

  int checks   = 0;
  int failures = 0;

  r_enc_ctrl #(
    .WIDTH(8), .MIN_VAL(0), .MAX_VAL(255), .INIT_VAL(0),
    .FAST_CYC(8), .FAST_STEP(8), .IDLE_CYC(20), .TW(26)
  ) dut (
    .clk(clk), .rst(rst), .rlr(rlr), .btn_press(btn_press),
    .value(value), .editing(editing), .commit_valid(commit_valid),
    .commit_ready(commit_ready), .commit_data(commit_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one event (optionally with button) for exactly one rising edge.
  task automatic send(input logic d, input logic btn);
    rlr       = {1'b1, d};
    btn_press = btn;
    @(negedge clk);
    rlr       = 2'b00;
    btn_press = 1'b0;
  endtask

  task automatic press();
    btn_press = 1'b1;
    @(negedge clk);
    btn_press = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    rst = 1'b1; rlr = 2'b00; btn_press = 1'b0; commit_ready = 1'b0;
    tick(3);
    check("rst_value", value, 0);
    check("rst_editing", editing, 0);
    check("rst_cvalid", commit_valid, 0);
    check("rst_cdata", commit_data, 0);
    rst = 1'b0;
    tick(1);

    // Slow right events: step 1 each
    send(1'b0, 1'b0);
    check("slow_v1", value, 1);
    check("slow_edit", editing, 1);
    tick(11); send(1'b0, 1'b0);
    check("slow_v2", value, 2);
    tick(11); send(1'b0, 1'b0);
    check("slow_v3", value, 3);
    check("slow_cvalid", commit_valid, 0);

    // Reach 10, then fast left events clamp at 0
    do_reset();
    send(1'b0, 1'b0);
    tick(1); send(1'b0, 1'b0);
    check("acc_v9", value, 9);
    tick(11); send(1'b0, 1'b0);
    check("acc_v10", value, 10);
    tick(1); send(1'b1, 1'b0);
    check("dec_dirchg", value, 9);
    tick(1); send(1'b1, 1'b0);
    check("dec_fast", value, 1);
    tick(1); send(1'b1, 1'b0);
    check("dec_clamp0", value, 0);
    tick(1); send(1'b1, 1'b0);
    check("dec_nowrap", value, 0);

    // Climb to 250, then fast right events clamp at 255
    do_reset();
    send(1'b0, 1'b0);
    repeat (31) begin tick(1); send(1'b0, 1'b0); end
    check("climb_249", value, 249);
    tick(11); send(1'b0, 1'b0);
    tick(11); send(1'b0, 1'b0);
    tick(1); send(1'b1, 1'b0);
    check("climb_250", value, 250);
    tick(1); send(1'b0, 1'b0);
    check("inc_251", value, 251);
    tick(1); send(1'b0, 1'b0);
    check("inc_clamp255", value, 255);
    tick(1); send(1'b0, 1'b0);
    check("inc_hold255", value, 255);

    // Button commit with backpressure; events ignored in COMMIT
    do_reset();
    send(1'b0, 1'b0);
    repeat (4) begin tick(11); send(1'b0, 1'b0); end
    check("btn_pre_v5", value, 5);
    tick(1); press();
    check("btn_cvalid", commit_valid, 1);
    check("btn_cdata", commit_data, 5);
    check("btn_noedit", editing, 0);
    for (int i = 0; i < 10; i++) begin
      rlr = {1'b1, i[0]};
      btn_press = i[1];
      @(negedge clk);
      check("hold_cvalid", commit_valid, 1);
      check("hold_cdata", commit_data, 5);
      check("hold_value", value, 5);
    end
    rlr = 2'b00; btn_press = 1'b0;
    commit_ready = 1'b1;
    tick(1);
    commit_ready = 1'b0;
    check("accept_cvalid", commit_valid, 0);
    check("accept_editing", editing, 0);
    check("accept_value", value, 5);

    // Inactivity auto-commit after IDLE_CYC cycles
    send(1'b0, 1'b0);
    tick(11); send(1'b0, 1'b0);
    check("to_v7", value, 7);
    tick(19);
    check("to_early", commit_valid, 0);
    tick(1);
    check("to_cvalid", commit_valid, 1);
    check("to_cdata", commit_data, 7);
    commit_ready = 1'b1;
    tick(1);
    commit_ready = 1'b0;
    check("to_accept", commit_valid, 0);

    // Same-cycle event and button, then reset during COMMIT
    send(1'b1, 1'b0);
    tick(11); send(1'b0, 1'b0);
    check("same_pre_v7", value, 7);
    tick(11); send(1'b0, 1'b1);
    check("same_value", value, 8);
    check("same_cdata", commit_data, 8);
    check("same_cvalid", commit_valid, 1);
    rst = 1'b1;
    #1;
    check("arst_cvalid", commit_valid, 0);
    check("arst_value", value, 0);
    check("arst_cdata", commit_data, 0);
    check("arst_editing", editing, 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    check("post_rst_cvalid", commit_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
